// File: rtl/leaf_dispatch_rr.sv
// Round-robin dispatcher: FIFO + registered output stage handing each word to one leaf lane in turn.
// Optional transfer counter on stat_cnt enabled by defining DISPATCH_STATS_EN.
module leaf_dispatch_rr #(
    parameter int DATA_W  = 16,
    parameter int NUM_OUT = 5,
    parameter int DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [$clog2(DEPTH+2)-1:0]    level,
    output logic [15:0]                   stat_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_OUT);
    localparam int LW = $clog2(DEPTH+2);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              r_in_ready;
    logic              r_or_full;
    logic [DATA_W-1:0] r_out_data;
    logic [PW-1:0]     r_rr_ptr;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_xfer;
    logic [AW:0]       w_count;
    logic [AW:0]       w_count_nxt;

    assign w_empty     = (r_wptr == r_rptr);
    assign w_count     = r_wptr - r_rptr;
    assign w_push      = in_valid && r_in_ready;
    assign w_xfer      = r_or_full && out_ready[r_rr_ptr];
    assign w_pop       = !w_empty && (!r_or_full || w_xfer);
    assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    // in_ready is registered from the post-edge occupancy, so it lags a same-cycle pop by one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_in_ready <= (w_count_nxt != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_or_full  <= 1'b0;
            r_out_data <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_pop) begin
                r_or_full  <= 1'b1;
                r_out_data <= r_mem[r_rptr[AW-1:0]];
            end else if (w_xfer) begin
                r_or_full  <= 1'b0;
            end
            if (w_xfer)
                r_rr_ptr <= (r_rr_ptr == PW'(NUM_OUT-1)) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_or_full ? (NUM_OUT'(1) << r_rr_ptr) : '0;
    assign out_data  = r_out_data;
    assign level     = LW'(w_count) + LW'(r_or_full);

`ifdef DISPATCH_STATS_EN
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stat_cnt <= '0;
        else if (w_xfer && (r_stat_cnt != 16'hFFFF))
            r_stat_cnt <= r_stat_cnt + 16'd1;
    end

    assign stat_cnt = r_stat_cnt;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_leaf_dispatch_rr.sv
// Directed bench for leaf_dispatch_rr: vector table for streaming/full/drain, hand sequences for reset and stats.
module tb_leaf_dispatch_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic [15:0] out_data;
    logic [2:0]  level;
    logic [15:0] stat_cnt;

    int total = 0;
    int bad   = 0;
    int exp_xfers = 0;

    always #5 clk = ~clk;

    leaf_dispatch_rr #(.DATA_W(16), .NUM_OUT(5), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .stat_cnt  (stat_cnt)
    );

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic [4:0]  rdy;
        logic        e_ir;
        logic [4:0]  e_ov;
        logic [15:0] e_od;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic [4:0] r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        //              iv  id        rdy       ir  ov        od        lvl
        vecs[0]  = '{1'b0, 16'h0000, 5'b00000, 1'b0, 5'b00000, 16'h0000, 3'd0};
        vecs[1]  = '{1'b1, 16'h1111, 5'b11111, 1'b1, 5'b00000, 16'h0000, 3'd0};
        vecs[2]  = '{1'b1, 16'h2222, 5'b11111, 1'b1, 5'b00000, 16'h0000, 3'd1};
        vecs[3]  = '{1'b1, 16'h3333, 5'b11111, 1'b1, 5'b00001, 16'h1111, 3'd2};
        vecs[4]  = '{1'b1, 16'h4444, 5'b11111, 1'b1, 5'b00010, 16'h2222, 3'd2};
        vecs[5]  = '{1'b1, 16'h5555, 5'b11111, 1'b1, 5'b00100, 16'h3333, 3'd2};
        vecs[6]  = '{1'b0, 16'h0000, 5'b11111, 1'b1, 5'b01000, 16'h4444, 3'd2};
        vecs[7]  = '{1'b0, 16'h0000, 5'b11111, 1'b1, 5'b10000, 16'h5555, 3'd1};
        vecs[8]  = '{1'b0, 16'h0000, 5'b00000, 1'b1, 5'b00000, 16'h5555, 3'd0};
        vecs[9]  = '{1'b1, 16'hA001, 5'b00000, 1'b1, 5'b00000, 16'h5555, 3'd0};
        vecs[10] = '{1'b1, 16'hA002, 5'b00000, 1'b1, 5'b00000, 16'h5555, 3'd1};
        vecs[11] = '{1'b1, 16'hA003, 5'b00000, 1'b1, 5'b00001, 16'hA001, 3'd2};
        vecs[12] = '{1'b1, 16'hA004, 5'b00000, 1'b1, 5'b00001, 16'hA001, 3'd3};
        vecs[13] = '{1'b1, 16'hA005, 5'b00000, 1'b1, 5'b00001, 16'hA001, 3'd4};
        vecs[14] = '{1'b1, 16'hA006, 5'b00000, 1'b0, 5'b00001, 16'hA001, 3'd5};
        vecs[15] = '{1'b1, 16'hA006, 5'b00001, 1'b0, 5'b00001, 16'hA001, 3'd5};
        vecs[16] = '{1'b1, 16'hA006, 5'b00000, 1'b1, 5'b00010, 16'hA002, 3'd4};
        vecs[17] = '{1'b0, 16'h0000, 5'b11101, 1'b0, 5'b00010, 16'hA002, 3'd5};
        vecs[18] = '{1'b0, 16'h0000, 5'b11111, 1'b0, 5'b00010, 16'hA002, 3'd5};
        vecs[19] = '{1'b0, 16'h0000, 5'b11111, 1'b1, 5'b00100, 16'hA003, 3'd4};
        vecs[20] = '{1'b0, 16'h0000, 5'b11111, 1'b1, 5'b01000, 16'hA004, 3'd3};
        vecs[21] = '{1'b0, 16'h0000, 5'b11111, 1'b1, 5'b10000, 16'hA005, 3'd2};
        vecs[22] = '{1'b0, 16'h0000, 5'b11111, 1'b1, 5'b00001, 16'hA006, 3'd1};
        vecs[23] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 5'b00000, 16'hA006, 3'd0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
            if ((vecs[i].e_ov & vecs[i].rdy) != 5'b0) exp_xfers++;
            step(vecs[i].iv, vecs[i].id, vecs[i].rdy);
        end

`ifdef DISPATCH_STATS_EN
        check("stat_after_table", 32'(stat_cnt), 32'(exp_xfers));
`else
        check("stat_after_table", 32'(stat_cnt), 32'd0);
`endif

        // rr_ptr is 1 here; move it to 2, then build level=3 with OR on lane 2
        step(1'b1, 16'hB001, 5'b00010);
        step(1'b0, 16'h0000, 5'b00010);
        step(1'b0, 16'h0000, 5'b00010);
        step(1'b1, 16'hB002, 5'b00000);
        step(1'b1, 16'hB003, 5'b00000);
        step(1'b1, 16'hB004, 5'b00000);
        in_valid = 1'b0;
        check("pre_rst_level", 32'(level), 32'd3);
        check("pre_rst_out_valid", 32'(out_valid), 32'b00100);
        check("pre_rst_out_data", 32'(out_data), 32'hB002);

        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_stat", 32'(stat_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'hC001, 5'b00000);
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_level0", 32'(level), 32'd0);
        step(1'b1, 16'hC001, 5'b00000);
        step(1'b0, 16'h0000, 5'b00000);
        check("postrst_lane0", 32'(out_valid), 32'b00001);
        check("postrst_data", 32'(out_data), 32'hC001);

`ifdef DISPATCH_STATS_EN
        force dut.r_stat_cnt = 16'hFFFE;
        #1;
        release dut.r_stat_cnt;
`endif
        step(1'b1, 16'hC002, 5'b11111);
        step(1'b1, 16'hC003, 5'b11111);
        step(1'b0, 16'h0000, 5'b11111);
        step(1'b0, 16'h0000, 5'b11111);
        check("final_level", 32'(level), 32'd0);
        check("final_out_valid", 32'(out_valid), 32'd0);
        check("final_out_data", 32'(out_data), 32'hC003);
`ifdef DISPATCH_STATS_EN
        check("stat_saturated", 32'(stat_cnt), 32'hFFFF);
`else
        check("stat_tied_zero", 32'(stat_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
